// File: rtl/down_count_ten.sv
`default_nettype none
// ============================================================================
//  Module      : down_count_ten
//  Description : Loadable, start-gated multi-digit BCD countdown timer with
//                optional wrap from zero to all-nines.
//  Revision    : 1.0
// ============================================================================
module down_count_ten #(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b0
) (
    input  logic                  clk,
    input  logic                  a_reset_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  expired,
    output logic                  done
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic           running_q, running_d;
    logic           expired_q, expired_d;
    logic           done_q, done_d;
    logic [W-1:0]   w_dec;
    logic [W-1:0]   w_san;
    logic           w_dec_ok;

    // Ripple-borrow BCD decrement of the current count, and per-digit
    // clamping of the preset so digits never hold A-F.
    always_comb begin : bcd_arith
        logic borrow;
        borrow = 1'b1;
        w_dec  = '0;
        w_san  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow && (count_q[4*i +: 4] == 4'd0)) begin
                w_dec[4*i +: 4] = 4'd9;
            end else if (borrow) begin
                w_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                borrow          = 1'b0;
            end else begin
                w_dec[4*i +: 4] = count_q[4*i +: 4];
            end
            w_san[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
        end
    end

    assign w_dec_ok = (count_q != '0) || WRAP;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = IDLE;
            count_d = w_san;
        end else if (state_q == EXPIRED) begin
            state_d = EXPIRED;
        end else if (start && w_dec_ok) begin
            count_d = w_dec;
            state_d = RUN;
            // Only a 1 -> 0 step lands on zero; the 0 -> all-nines wrap never does.
            if (w_dec == '0) begin
                done_d = 1'b1;
                if (!WRAP) begin
                    state_d = EXPIRED;
                end
            end
        end else begin
            state_d = IDLE;
        end
        running_d = (state_d == RUN);
        expired_d = (state_d == EXPIRED);
    end

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            running_q <= running_d;
            expired_q <= expired_d;
            done_q    <= done_d;
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign expired = expired_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_down_count_ten.sv
`default_nettype none
// ============================================================================
//  Module      : tb_down_count_ten
//  Description : Directed and randomized check of down_count_ten (DIGITS=2)
//                in stop and wrap modes against a decimal reference model.
//  Revision    : 1.0
// ============================================================================
module tb_down_count_ten;

    logic       clk = 1'b0;
    logic       a_reset_n;
    logic       load;
    logic       start;
    logic [7:0] load_val;

    logic [7:0] cnt0, cnt1;
    logic       run0, run1, exp0, exp1, dn0, dn1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: count kept as a plain decimal integer 0..99.
    // m_st: 0 = idle, 1 = run, 2 = expired. Index 0 = stop mode, 1 = wrap mode.
    int m_val [2];
    int m_st  [2];
    bit m_done[2];

    always #5 clk = ~clk;

    down_count_ten #(.DIGITS(2), .WRAP(1'b0)) u_dut_stop (
        .clk       (clk),
        .a_reset_n (a_reset_n),
        .load      (load),
        .load_val  (load_val),
        .start     (start),
        .count     (cnt0),
        .running   (run0),
        .expired   (exp0),
        .done      (dn0)
    );

    down_count_ten #(.DIGITS(2), .WRAP(1'b1)) u_dut_wrap (
        .clk       (clk),
        .a_reset_n (a_reset_n),
        .load      (load),
        .load_val  (load_val),
        .start     (start),
        .count     (cnt1),
        .running   (run1),
        .expired   (exp1),
        .done      (dn1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_val[i]  = 0;
            m_st[i]   = 0;
            m_done[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int hi, lo;
        hi = (load_val[7:4] > 9) ? 9 : int'(load_val[7:4]);
        lo = (load_val[3:0] > 9) ? 9 : int'(load_val[3:0]);
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 1'b0;
            if (load) begin
                m_val[i] = hi * 10 + lo;
                m_st[i]  = 0;
            end else if (m_st[i] == 2) begin
                m_st[i] = 2;
            end else if (start && (m_val[i] != 0 || i == 1)) begin
                m_val[i]  = (m_val[i] == 0) ? 99 : m_val[i] - 1;
                m_done[i] = (m_val[i] == 0);
                m_st[i]   = (m_done[i] && i == 0) ? 2 : 1;
            end else begin
                m_st[i] = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_cnt_stop"}, 32'(cnt0), 32'(to_bcd(m_val[0])));
        check({tag, "_run_stop"}, 32'(run0), 32'(m_st[0] == 1));
        check({tag, "_exp_stop"}, 32'(exp0), 32'(m_st[0] == 2));
        check({tag, "_done_stop"}, 32'(dn0), 32'(m_done[0]));
        check({tag, "_cnt_wrap"}, 32'(cnt1), 32'(to_bcd(m_val[1])));
        check({tag, "_run_wrap"}, 32'(run1), 32'(m_st[1] == 1));
        check({tag, "_exp_wrap"}, 32'(exp1), 32'(m_st[1] == 2));
        check({tag, "_done_wrap"}, 32'(dn1), 32'(m_done[1]));
    endtask

    // One rising edge: inputs were set away from the edge; outputs are
    // compared on the following falling edge.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        step("load");
        load     = 1'b0;
    endtask

    initial begin
        a_reset_n = 1'b0;
        load      = 1'b0;
        start     = 1'b0;
        load_val  = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        a_reset_n = 1'b1;

        // Async reset mid-period while running from 0x37.
        do_load(8'h37);
        start = 1'b1;
        repeat (3) step("s1_run");
        #2;
        a_reset_n = 1'b0;
        #1;
        model_reset();
        check_all("s1_async");
        check("s1_async_cnt", 32'(cnt0), 32'h00);
        @(negedge clk);
        check_all("s1_held");
        a_reset_n = 1'b1;
        repeat (3) step("s1_zero");
        check("s1_zero_cnt", 32'(cnt0), 32'h00);
        check("s1_zero_done", 32'(dn0), 32'h0);

        // Countdown through a digit borrow to expiry.
        start = 1'b0;
        do_load(8'h12);
        start = 1'b1;
        step("s2");
        check("s2_first", 32'(cnt0), 32'h11);
        step("s2");
        step("s2");
        check("s2_borrow", 32'(cnt0), 32'h09);
        repeat (9) step("s2");
        check("s2_zero", 32'(cnt0), 32'h00);
        check("s2_done", 32'(dn0), 32'h1);
        check("s2_expired", 32'(exp0), 32'h1);
        repeat (3) step("s2_hold");
        check("s2_hold_cnt", 32'(cnt0), 32'h00);
        check("s2_hold_done", 32'(dn0), 32'h0);

        // Load out of EXPIRED.
        start = 1'b0;
        do_load(8'h05);
        check("s6_exp", 32'(exp0), 32'h0);
        check("s6_cnt", 32'(cnt0), 32'h05);
        start = 1'b1;
        step("s6");
        check("s6_dec", 32'(cnt0), 32'h04);

        // Pause and resume.
        start = 1'b0;
        do_load(8'h25);
        start = 1'b1;
        repeat (3) step("s3_run");
        check("s3_cnt", 32'(cnt0), 32'h22);
        start = 1'b0;
        repeat (4) step("s3_pause");
        check("s3_pause_cnt", 32'(cnt0), 32'h22);
        check("s3_pause_run", 32'(run0), 32'h0);
        start = 1'b1;
        step("s3_resume");
        check("s3_resume_cnt", 32'(cnt0), 32'h21);

        // Sanitize and load-over-start priority.
        start = 1'b0;
        do_load(8'hAF);
        check("s4_sanitize", 32'(cnt0), 32'h99);
        start = 1'b1;
        do_load(8'h40);
        check("s4_prio_cnt", 32'(cnt0), 32'h40);
        check("s4_prio_run", 32'(run0), 32'h0);
        step("s4_next");
        check("s4_next_cnt", 32'(cnt0), 32'h39);

        // Wrap mode through zero.
        start = 1'b0;
        do_load(8'h02);
        start = 1'b1;
        step("s5");
        check("s5_01", 32'(cnt1), 32'h01);
        step("s5");
        check("s5_00", 32'(cnt1), 32'h00);
        check("s5_done", 32'(dn1), 32'h1);
        step("s5");
        check("s5_99", 32'(cnt1), 32'h99);
        check("s5_nodone", 32'(dn1), 32'h0);
        check("s5_running", 32'(run1), 32'h1);
        step("s5");
        check("s5_98", 32'(cnt1), 32'h98);
        check("s5_expired", 32'(exp1), 32'h0);

        // Randomized traffic: sparse loads of small/illegal presets,
        // mostly-high start, occasional async reset between edges.
        for (int k = 0; k < 3000; k++) begin
            load     = ($urandom_range(0, 15) == 0);
            load_val = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom);
            start    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                a_reset_n = 1'b0;
                #1;
                model_reset();
                check_all("rnd_async");
                @(negedge clk);
                a_reset_n = 1'b1;
            end
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
